// File: rtl/ahb_uvc_pkg.sv
// Shared AHB-Lite types and widths for the slave memory model and its bench.
package ahb_uvc_pkg;

  localparam int HTRANS_W = 2;
  localparam int HSIZE_W  = 3;
  localparam int HBURST_W = 3;
  localparam int HPROT_W  = 4;

  typedef enum logic [HTRANS_W-1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [HSIZE_W-1:0] {
    BYTE  = 3'd0,
    HALF  = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3
  } hsize_e;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

  // A byte is enabled when it falls in the same size-aligned group as the address.
  function automatic logic [7:0] byte_enables(input logic [2:0] lane, input logic [2:0] size);
    logic [7:0] be;
    for (int unsigned i = 0; i < 8; i++) begin
      be[i] = ((3'(i) >> size) == (lane >> size));
    end
    return be;
  endfunction

endpackage

// File: rtl/ahb_slave_mem_array.sv
// Byte-enabled word memory: one synchronous write port, one combinational read port.
module ahb_slave_mem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned IDX_W      = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [IDX_W-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < DATA_WIDTH/8; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory responder with configurable wait states and two-cycle ERROR.
module ahb_slave_mem
  import ahb_uvc_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  Hsel,
  input  logic [ADDR_WIDTH-1:0] Haddr,
  input  logic [HTRANS_W-1:0]   Htrans,
  input  logic                  Hwrite,
  input  logic [HSIZE_W-1:0]    Hsize,
  input  logic [HBURST_W-1:0]   Hburst,
  input  logic [HPROT_W-1:0]    Hprot,
  input  logic                  Hmastlock,
  input  logic [DATA_WIDTH-1:0] Hwdata,
  input  logic                  Hready_in,
  output logic [DATA_WIDTH-1:0] Hrdata,
  output logic                  Hready_out,
  output logic                  Hresp
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned LANE_W = $clog2(BYTES);
  localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);

  slave_state_e          state;
  logic [3:0]            cnt;
  logic [IDX_W-1:0]      idx_q, idx_now, rd_idx;
  logic [BYTES-1:0]      be_q, be_now;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] offset;
  logic [7:0]            be_full, align_mask;
  logic                  in_range, too_big, misaligned, err_now;
  logic                  can_accept, accept, we, fwd;
  logic [DATA_WIDTH-1:0] mem_rdata, rd_word;
  logic                  unused_bits;

  assign offset     = Haddr - BASE_ADDR;
  assign in_range   = (Haddr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign too_big    = Hsize > HSIZE_W'(LANE_W);
  assign align_mask = (8'd1 << Hsize) - 8'd1;
  assign misaligned = |(Haddr[LANE_W-1:0] & align_mask[LANE_W-1:0]);
  assign err_now    = !in_range || too_big || misaligned;
  assign idx_now    = offset[LANE_W +: IDX_W];
  assign be_full    = byte_enables(3'(Haddr[LANE_W-1:0]), Hsize);
  assign be_now     = be_full[BYTES-1:0];

  assign can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign accept     = can_accept && Hsel && Hready_in && Htrans[1];
  assign we         = (state == ST_DATA) && write_q && !hreset;

  // A read accepted while the previous write is still in DATA sees that write's
  // bytes by forwarding Hwdata, since the array commits only at the closing edge.
  assign rd_idx = (state == ST_WAIT) ? idx_q : idx_now;
  assign fwd    = (state == ST_DATA) && write_q && (idx_q == rd_idx);

  always_comb begin
    rd_word = mem_rdata;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (fwd && be_q[i]) rd_word[8*i +: 8] = Hwdata[8*i +: 8];
    end
  end

  ahb_slave_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk  (hclk),
    .we   (we),
    .be   (be_q),
    .waddr(idx_q),
    .wdata(Hwdata),
    .raddr(rd_idx),
    .rdata(mem_rdata)
  );

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      Hready_out <= 1'b1;
      Hresp      <= OKAY;
      Hrdata     <= '0;
    end else begin
      Hrdata <= '0;
      unique case (state)
        ST_WAIT: begin
          if (cnt == '0) begin
            state      <= ST_DATA;
            Hready_out <= 1'b1;
            Hrdata     <= write_q ? '0 : rd_word;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state      <= ST_ERR2;
          Hready_out <= 1'b1;
          Hresp      <= ERROR;
        end
        default: begin
          if (accept) begin
            idx_q   <= idx_now;
            be_q    <= be_now;
            write_q <= Hwrite;
            if (err_now) begin
              state      <= ST_ERR1;
              Hready_out <= 1'b0;
              Hresp      <= ERROR;
            end else if (WAIT_STATES > 0) begin
              state      <= ST_WAIT;
              cnt        <= 4'(WAIT_STATES - 1);
              Hready_out <= 1'b0;
              Hresp      <= OKAY;
            end else begin
              state      <= ST_DATA;
              Hready_out <= 1'b1;
              Hresp      <= OKAY;
              Hrdata     <= Hwrite ? '0 : rd_word;
            end
          end else begin
            state      <= ST_IDLE;
            Hready_out <= 1'b1;
            Hresp      <= OKAY;
          end
        end
      endcase
    end
  end

  assign unused_bits = ^{Hburst, Hprot, Hmastlock, Htrans, offset, be_full};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: two instances (zero-wait, 3-wait with offset base) against a byte-level model.
module tb_ahb_slave_mem;
  import ahb_uvc_pkg::*;

  typedef struct {
    bit          sel;
    logic [1:0]  tr;
    bit          wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    bit          hold;
  } tx_t;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        sel0, sel1, hold;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [31:0] rdata0, rdata1;
  logic        rdy0, rdy1, resp0, resp1, hrin0, hrin1;

  int errors = 0;
  int checks = 0;
  logic [7:0]  mm [2][4096];
  int unsigned base_a [2] = '{32'h0, 32'h4000};
  int unsigned span_b [2] = '{4096, 1024};
  int unsigned ws     [2] = '{0, 3};
  tx_t         q[$];
  logic [31:0] last_rd;

  always #5 hclk = ~hclk;

  assign hrin0 = rdy0 & ~hold;
  assign hrin1 = rdy1 & ~hold;

  ahb_slave_mem #(.WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hreset(hreset), .Hsel(sel0), .Haddr(haddr), .Htrans(htrans),
    .Hwrite(hwrite), .Hsize(hsize), .Hburst(hburst), .Hprot(4'd3), .Hmastlock(1'b0),
    .Hwdata(hwdata), .Hready_in(hrin0), .Hrdata(rdata0), .Hready_out(rdy0), .Hresp(resp0)
  );

  ahb_slave_mem #(.BASE_ADDR(32'h0000_4000), .MEM_DEPTH(256), .WAIT_STATES(3)) dut1 (
    .hclk(hclk), .hreset(hreset), .Hsel(sel1), .Haddr(haddr), .Htrans(htrans),
    .Hwrite(hwrite), .Hsize(hsize), .Hburst(hburst), .Hprot(4'd3), .Hmastlock(1'b0),
    .Hwdata(hwdata), .Hready_in(hrin1), .Hrdata(rdata1), .Hready_out(rdy1), .Hresp(resp1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic out_rdy(input int d);
    return (d != 0) ? rdy1 : rdy0;
  endfunction
  function automatic logic out_resp(input int d);
    return (d != 0) ? resp1 : resp0;
  endfunction
  function automatic logic [31:0] out_rdata(input int d);
    return (d != 0) ? rdata1 : rdata0;
  endfunction
  function automatic logic bus_rdy(input int d);
    return (d != 0) ? hrin1 : hrin0;
  endfunction

  function automatic bit is_err(input int d, input logic [31:0] a, input logic [2:0] s);
    longint off = longint'(a) - longint'(base_a[d]);
    if (s > 3'd2) return 1'b1;
    if (off < 0 || off >= longint'(span_b[d])) return 1'b1;
    if ((a % (32'd1 << s)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
    int unsigned o = (a - base_a[d]) & ~32'd3;
    return {mm[d][o+3], mm[d][o+2], mm[d][o+1], mm[d][o]};
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] data);
    int unsigned o = a - base_a[d];
    for (int unsigned b = 0; b < (32'd1 << s); b++) begin
      mm[d][o+b] = data[8*((o+b)%4) +: 8];
    end
  endtask

  function automatic tx_t mk(input bit sel, input logic [1:0] tr, input bit wr,
                             input logic [2:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input bit hd);
    tx_t t;
    t.sel = sel; t.tr = tr; t.wr = wr; t.sz = sz; t.a = a; t.wd = wd; t.hold = hd;
    return t;
  endfunction

  function automatic tx_t idle_tx();
    return mk(1'b0, IDLE, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
  endfunction
  function automatic tx_t w_tx(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    return mk(1'b1, NONSEQ, 1'b1, sz, a, d, 1'b0);
  endfunction
  function automatic tx_t r_tx(input logic [31:0] a);
    return mk(1'b1, NONSEQ, 1'b0, 3'd2, a, 32'h0, 1'b0);
  endfunction

  function automatic tx_t rnd_tx(input int d);
    tx_t t;
    int unsigned k = $urandom_range(0, 15);
    logic [2:0]  sz = 3'($urandom_range(0, 2));
    logic [31:0] off = 32'h100 + ($urandom_range(0, 63) & ~((32'd1 << sz) - 32'd1));
    t = mk(1'b1, ($urandom_range(0, 1) != 0) ? SEQ : NONSEQ, 1'($urandom), sz,
           base_a[d] + off, $urandom, 1'b0);
    case (k)
      0: begin t.sz = 3'd2; t.a = base_a[d] + 32'h100 + 32'($urandom_range(1, 3)); end
      1: t.sz = 3'd3;
      2: t.a = base_a[d] + span_b[d];
      3: t.tr = BUSY;
      4: t.sel = 1'b0;
      default: ;
    endcase
    return t;
  endfunction

  // Pipelined master: address phase of q[cur] overlaps the data phase of dp.
  task automatic run(input int d);
    int unsigned cur = 0, waits = 0, cycles = 0;
    bit  dp_v = 1'b0, rdy, act, e;
    tx_t dp, t;
    dp = idle_tx();
    while (cur < q.size() || dp_v) begin
      t = (cur < q.size()) ? q[cur] : idle_tx();
      sel0   = (d == 0) && t.sel;
      sel1   = (d == 1) && t.sel;
      haddr  = t.a;
      htrans = t.tr;
      hwrite = t.wr;
      hsize  = t.sz;
      hold   = t.hold;
      hburst = 3'($urandom);
      hwdata = (dp_v && dp.wr) ? dp.wd : $urandom;
      #1;
      rdy = bus_rdy(d);
      act = dp_v && dp.sel && dp.tr[1];
      e   = act && is_err(d, dp.a, dp.sz);
      chk("hresp", out_resp(d), e);
      if (!act) chk("idle_ready", out_rdy(d), 1);
      if (rdy && act && !e && !dp.wr) begin
        last_rd = out_rdata(d);
        chk("hrdata", out_rdata(d), model_word(d, dp.a));
      end else begin
        chk("hrdata_zero", out_rdata(d), 0);
      end
      if (act && !out_rdy(d)) waits++;
      if (rdy && act) chk("wait_cycles", waits, e ? 1 : ws[d]);
      @(posedge hclk);
      if (rdy) begin
        if (act && !e && dp.wr) model_write(d, dp.a, dp.sz, dp.wd);
        dp_v  = (cur < q.size());
        dp    = t;
        waits = 0;
        if (cur < q.size()) cur++;
      end else if (t.hold) begin
        cur++;
      end
      #1;
      cycles++;
      if (cycles > 2000) begin
        chk("timeout", cycles, 0);
        break;
      end
    end
    sel0 = 1'b0; sel1 = 1'b0; htrans = IDLE; hold = 1'b0;
    q.delete();
  endtask

  initial begin
    hreset = 1'b1; sel0 = 1'b0; sel1 = 1'b0; hold = 1'b0; htrans = IDLE;
    haddr = '0; hwrite = 1'b0; hsize = 3'd2; hburst = '0; hwdata = '0;
    @(posedge hclk); #1;
    chk("rst_ready0", rdy0, 1);  chk("rst_resp0", resp0, 0);  chk("rst_rdata0", rdata0, 0);
    chk("rst_ready1", rdy1, 1);  chk("rst_resp1", resp1, 0);  chk("rst_rdata1", rdata1, 0);
    @(posedge hclk); #1;
    hreset = 1'b0;

    // zero-wait instance: write then read back-to-back
    q.push_back(w_tx(32'h10, 3'd2, 32'hDEAD_BEEF));
    q.push_back(r_tx(32'h10));
    run(0);
    chk("raw_forward", last_rd, 32'hDEAD_BEEF);

    q.push_back(w_tx(32'h20, 3'd2, 32'h0));
    q.push_back(w_tx(32'h22, 3'd0, 32'h00AB_0000));
    q.push_back(w_tx(32'h20, 3'd1, 32'h0000_1234));
    q.push_back(r_tx(32'h20));
    run(0);
    chk("byte_lanes", last_rd, 32'h00AB_1234);

    q.push_back(w_tx(32'h30, 3'd2, 32'h1122_3344));
    q.push_back(w_tx(32'h33, 3'd2, 32'hFFFF_FFFF));
    q.push_back(idle_tx());
    q.push_back(w_tx(32'h1000, 3'd2, 32'hFFFF_FFFF));
    q.push_back(idle_tx());
    q.push_back(mk(1'b1, BUSY, 1'b1, 3'd2, 32'h30, 32'hEEEE_EEEE, 1'b0));
    q.push_back(mk(1'b0, NONSEQ, 1'b1, 3'd2, 32'h30, 32'hDDDD_DDDD, 1'b0));
    q.push_back(idle_tx());
    q.push_back(mk(1'b1, NONSEQ, 1'b1, 3'd2, 32'h30, 32'hCCCC_CCCC, 1'b1));
    q.push_back(r_tx(32'h30));
    run(0);
    chk("err_mem_kept", last_rd, 32'h1122_3344);

    // 3-wait instance: fill window, pipelined NONSEQ+SEQ reads, errors
    for (int unsigned w = 0; w < 16; w++) q.push_back(w_tx(32'h4100 + 4*w, 3'd2, $urandom));
    q.push_back(w_tx(32'h4104, 3'd2, 32'h5555_AAAA));
    q.push_back(r_tx(32'h4100));
    q.push_back(mk(1'b1, SEQ, 1'b0, 3'd2, 32'h4104, 32'h0, 1'b0));
    q.push_back(w_tx(32'h4003, 3'd2, 32'h0));
    q.push_back(idle_tx());
    q.push_back(r_tx(32'h3FFC));
    q.push_back(idle_tx());
    q.push_back(r_tx(32'h4400));
    run(1);

    // reset while a write sits in WAIT
    sel1 = 1'b1; haddr = 32'h4104; htrans = NONSEQ; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    chk("rst_wait_entered", rdy1, 0);
    sel1 = 1'b0; htrans = IDLE; hwdata = 32'hCAFE_F00D;
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    chk("rst_abort_ready", rdy1, 1);
    chk("rst_abort_resp", resp1, 0);
    q.push_back(r_tx(32'h4104));
    run(1);
    chk("rst_write_dropped", last_rd, 32'h5555_AAAA);

    // randomized traffic on both instances over an initialised window
    for (int d = 0; d < 2; d++) begin
      for (int unsigned w = 0; w < 16; w++)
        q.push_back(w_tx(base_a[d] + 32'h100 + 4*w, 3'd2, $urandom));
      for (int n = 0; n < 60; n++) q.push_back(rnd_tx(d));
      run(d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB-Lite responder with a word-organised internal memory. It sits on the slave side of the bus and answers every transfer addressed to it. It supports configurable wait states, byte/halfword/word accesses and the two-cycle ERROR response. Benches use it as the reference target for the master driver and monitor.

Parameters:
ADDR_WIDTH, 32, Haddr width
DATA_WIDTH, 32, Hwdata/Hrdata width; 32 or 64 only
MEM_DEPTH, 1024, memory size in DATA_WIDTH-bit words
BASE_ADDR, 32'h0000_0000, byte address of word 0
WAIT_STATES, 0, Hready_out-low cycles inserted before the final data-phase cycle of every OKAY transfer (0..15)

Ports:
hclk  in  1  bus clock; all logic is on the rising edge
hreset  in  1  synchronous, active-high reset
Hsel  in  1  slave select from the decoder
Haddr  in  ADDR_WIDTH  transfer address
Htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
Hwrite  in  1  1 = write
Hsize  in  3  transfer size; log2 of bytes
Hburst  in  3  accepted and ignored; each beat is handled independently
Hprot  in  4  accepted and ignored
Hmastlock  in  1  accepted and ignored
Hwdata  in  DATA_WIDTH  write data, valid in the data phase
Hready_in  in  1  bus HREADY; an address phase completes only when this is high
Hrdata  out  DATA_WIDTH  read data
Hready_out  out  1  this slave's HREADY
Hresp  out  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset (hreset high at an edge): Hready_out=1, Hresp=0, Hrdata=0; FSM goes to IDLE and the wait counter clears. Memory contents are not reset.
- Reset mid-transfer aborts the transfer. A pending write is not committed.
- Address phase is accepted when, at an edge, Hsel && Hready_in && Htrans[1] are all true. The slave then registers addr, write, size and an error flag.
- Hsel low, IDLE or BUSY with Hready_in high: next cycle is a zero-wait OKAY (Hready_out=1, Hresp=0). Memory is untouched.
- Error flag is set for any of:
  - address outside [BASE_ADDR, BASE_ADDR + MEM_DEPTH*DATA_WIDTH/8)
  - Hsize > log2(DATA_WIDTH/8)
  - address not aligned to Hsize
- FSM states:
  - IDLE: Hready_out=1, Hresp=0. On an accepted transfer go to ERR1 if the error flag is set. Otherwise go to WAIT if WAIT_STATES>0, else to DATA.
  - WAIT: Hready_out=0, Hresp=0. The counter loads WAIT_STATES-1 on entry and decrements each cycle. Go to DATA at 0.
  - DATA: Hready_out=1, Hresp=0. This is the final cycle. Writes commit at the closing edge. Read data is valid on Hrdata during this cycle. A new address phase accepted at the same edge (pipelined) follows the IDLE rules; otherwise go to IDLE.
  - ERR1: Hready_out=0, Hresp=1. Always go to ERR2. The new address phase is not sampled here.
  - ERR2: Hready_out=1, Hresp=1. Memory is untouched. An address phase accepted at this edge follows the IDLE rules; the master normally drives IDLE here.
- No wait states are ever inserted before ERR1.
- Byte lanes are little-endian. The lane is selected by addr[log2(DATA_WIDTH/8)-1:0] and size. Writes update only the selected bytes. Reads return the full word; unselected lanes carry memory contents.
- Read-after-write: a read whose address phase overlaps the previous write's DATA cycle must return the newly written bytes. Use forwarding or read after commit.
- Hrdata=0 in every cycle other than a read's DATA cycle.
- With WAIT_STATES=0, back-to-back NONSEQ/SEQ beats complete one per cycle.

Decomposition:
- Shared package ahb_uvc_pkg holds:
  - htrans_e (IDLE/BUSY/NONSEQ/SEQ)
  - hsize_e (BYTE..DWORD)
  - hresp_e (OKAY/ERROR)
  - slave FSM state enum
  - HTRANS/HSIZE/HBURST/HPROT width constants, shared with the interface
- One natural sub-module: ahb_slave_mem_array. It is a byte-enabled single-port memory with one write port and a read port that is combinational or registered.

Test Plan:
- Reset: hreset high for 2 cycles -> Hready_out=1, Hresp=0, Hrdata=0 on the first cycle after the reset edge.
- Word write then read, WAIT_STATES=0: write 32'hDEAD_BEEF to 0x10, then read 0x10 back-to-back -> Hready_out stays 1 and Hrdata=32'hDEAD_BEEF in the read's data cycle (RAW forwarding).
- Byte lanes:
  - Setup: write word 32'h0 to 0x20.
  - Byte write: Hsize=0 at 0x22 with Hwdata=32'h00AB_0000.
  - Halfword write: Hsize=1 at 0x20 with Hwdata=32'h0000_1234.
  - Expected: a word read of 0x20 returns 32'h00AB_1234.
- Wait states, WAIT_STATES=3: NONSEQ read -> Hready_out low for exactly 3 cycles, then high for 1 cycle with valid data. A SEQ beat issued behind it is held until Hready_out returns high.
- Error response:
  - Misaligned: word access to 0x03 -> ERR1 (Hready_out=0, Hresp=1), then ERR2 (Hready_out=1, Hresp=1). Memory is unchanged.
  - Out of range: access to BASE_ADDR + 4*MEM_DEPTH -> same two-cycle ERROR response.
- IDLE/BUSY/unselected and mid-transfer reset:
  - BUSY, Hsel=0 and Hready_in=0 cycles -> zero-wait OKAY with no memory change.
  - hreset asserted in WAIT of a write -> Hready_out=1, and a later read shows the old data.
